// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: owns the PC, drives the word-addressed instruction memory and
// captures the fetched word into the IF/ID register, with stall/flush/redirect and halt/fault handling.
module if_stage_unit #(
   parameter int          XLEN         = 32,
   parameter int          IMEM_AW      = 6,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_target,
   input  logic               halt,
   input  logic               resume,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_inst,
   output logic [XLEN-1:0]    pc,
   output logic               id_valid,
   output logic [31:0]        id_inst,
   output logic [XLEN-1:0]    id_pc,
   output logic [XLEN-1:0]    id_pc_plus4,
   output logic               halted,
   output logic               fault,
   output logic [31:0]        fetch_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   state_t state;

   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] value);
      pc_inc = value + XLEN'(4);
   endfunction

   function automatic logic is_aligned(input logic [XLEN-1:0] target);
      is_aligned = (target[1:0] == 2'b00);
   endfunction

   logic redirect_ok;
   logic redirect_bad;
   logic bubble;
   logic capture;

   assign redirect_ok  = redirect_valid &&  is_aligned(redirect_target);
   assign redirect_bad = redirect_valid && !is_aligned(redirect_target);

   // A misaligned redirect also counts as a redirect for IF/ID, so the slot is squashed.
   assign bubble  = (state != RUN) || redirect_valid || flush || halt;
   assign capture = !bubble && !stall;

   assign imem_addr = pc[IMEM_AW+1:2];

   // Control FSM and program counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= RUN;
         halted <= 1'b0;
         fault  <= 1'b0;
         pc     <= RESET_VECTOR;
      end else begin
         case (state)
            RUN: begin
               if (redirect_bad) begin
                  state <= FAULT;
                  fault <= 1'b1;
               end else begin
                  if (halt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end
                  if (redirect_ok)
                     pc <= redirect_target;
                  else if (!(halt || stall))
                     pc <= pc_inc(pc);
               end
            end
            HALTED: begin
               if (!halt && resume) begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state  <= FAULT;
               halted <= 1'b0;
               fault  <= 1'b1;
            end
         endcase
      end
   end

   // IF/ID pipeline register and fetch counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         id_valid    <= 1'b0;
         id_inst     <= NOP_INST;
         id_pc       <= '0;
         id_pc_plus4 <= '0;
         fetch_count <= '0;
      end else if (bubble) begin
         id_valid <= 1'b0;
         id_inst  <= NOP_INST;
      end else if (capture) begin
         id_valid    <= 1'b1;
         id_inst     <= imem_inst;
         id_pc       <= pc;
         id_pc_plus4 <= pc_inc(pc);
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_if_stage_unit.sv
// Directed testbench for if_stage_unit: sequential fetch, stall, redirect, flush, halt/resume,
// misaligned-redirect fault and PC wrap-around (second instance with a high reset vector).
module tb_if_stage_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0, halt = 1'b0, resume = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [5:0]  imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] pc, id_inst, id_pc, id_pc_plus4, fetch_count;
   logic        id_valid, halted, fault;

   logic        w_rst = 1'b0;
   logic        w_zero = 1'b0;
   logic [31:0] w_target = '0;
   logic [5:0]  w_imem_addr;
   logic [31:0] w_imem_inst;
   logic [31:0] w_pc, w_id_inst, w_id_pc, w_id_pc_plus4, w_fetch_count;
   logic        w_id_valid, w_halted, w_fault;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Memory word k holds 0x100 + k.
   assign imem_inst   = 32'h100 + {26'd0, imem_addr};
   assign w_imem_inst = 32'h100 + {26'd0, w_imem_addr};

   if_stage_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt(halt), .resume(resume), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .pc(pc), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_pc_plus4(id_pc_plus4), .halted(halted), .fault(fault), .fetch_count(fetch_count)
   );

   if_stage_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(w_rst), .stall(w_zero), .flush(w_zero),
      .redirect_valid(w_zero), .redirect_target(w_target),
      .halt(w_zero), .resume(w_zero), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
      .pc(w_pc), .id_valid(w_id_valid), .id_inst(w_id_inst), .id_pc(w_id_pc),
      .id_pc_plus4(w_id_pc_plus4), .halted(w_halted), .fault(w_fault), .fetch_count(w_fetch_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      total++; if (id_inst !== 32'h13) begin bad++; $display("FAIL reset_inst got=%h exp=13", id_inst); end
      total++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_idpc got=%h/%h exp=0/0", id_pc, id_pc_plus4); end
      total++; if (halted !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", halted, fault); end
      total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      total++; if (imem_addr !== 6'd0) begin bad++; $display("FAIL reset_imem_addr got=%0d exp=0", imem_addr); end
      rst = 1'b1;
   endtask

   task automatic test_seq_fetch();
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_inst !== 32'(256+k) ||
             id_pc_plus4 !== 32'(4*k+4) || fetch_count !== 32'(k+1)) begin
            bad++;
            $display("FAIL seq_fetch[%0d] got v=%b pc=%h inst=%h p4=%h cnt=%0d exp v=1 pc=%h inst=%h p4=%h cnt=%0d",
                     k, id_valid, id_pc, id_inst, id_pc_plus4, fetch_count, 4*k, 256+k, 4*k+4, k+1);
         end
      end
      total++; if (pc !== 32'h10 || imem_addr !== 6'd4) begin bad++; $display("FAIL seq_pc got=%h/%0d exp=10/4", pc, imem_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      total++; if (pc !== 32'h8) begin bad++; $display("FAIL stall_setup_pc got=%h exp=8", pc); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (pc !== 32'h8 || id_pc !== 32'h4 || id_inst !== 32'h101 || id_valid !== 1'b1 || fetch_count !== 32'd2) begin
            bad++;
            $display("FAIL stall_hold[%0d] got pc=%h idpc=%h inst=%h v=%b cnt=%0d exp pc=8 idpc=4 inst=101 v=1 cnt=2",
                     i, pc, id_pc, id_inst, id_valid, fetch_count);
         end
      end
      stall = 1'b0;
      tick();
      total++;
      if (id_pc !== 32'h8 || id_inst !== 32'h102 || fetch_count !== 32'd3 || pc !== 32'hC) begin
         bad++;
         $display("FAIL stall_resume got idpc=%h inst=%h cnt=%0d pc=%h exp idpc=8 inst=102 cnt=3 pc=c", id_pc, id_inst, fetch_count, pc);
      end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 32'h40;
      tick();
      stall = 1'b0;
      redirect_valid = 1'b0;
      total++;
      if (pc !== 32'h40 || id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h8 || fetch_count !== 32'd3) begin
         bad++;
         $display("FAIL redir_bubble got pc=%h v=%b inst=%h idpc=%h cnt=%0d exp pc=40 v=0 inst=13 idpc=8 cnt=3", pc, id_valid, id_inst, id_pc, fetch_count);
      end
      tick();
      total++;
      if (id_pc !== 32'h40 || id_valid !== 1'b1 || id_inst !== 32'h110 || id_pc_plus4 !== 32'h44 || fetch_count !== 32'd4) begin
         bad++;
         $display("FAIL redir_capture got idpc=%h v=%b inst=%h p4=%h cnt=%0d exp idpc=40 v=1 inst=110 p4=44 cnt=4", id_pc, id_valid, id_inst, id_pc_plus4, fetch_count);
      end
   endtask

   task automatic test_flush_stall();
      flush = 1'b1;
      stall = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      total++;
      if (pc !== 32'h44 || id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h40 || fetch_count !== 32'd4) begin
         bad++;
         $display("FAIL flush_stall got pc=%h v=%b inst=%h idpc=%h cnt=%0d exp pc=44 v=0 inst=13 idpc=40 cnt=4", pc, id_valid, id_inst, id_pc, fetch_count);
      end
      tick();
      total++;
      if (id_pc !== 32'h44 || id_inst !== 32'h111 || id_valid !== 1'b1 || fetch_count !== 32'd5) begin
         bad++;
         $display("FAIL flush_after got idpc=%h inst=%h v=%b cnt=%0d exp idpc=44 inst=111 v=1 cnt=5", id_pc, id_inst, id_valid, fetch_count);
      end
   endtask

   task automatic test_halt_resume();
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      halt = 1'b1;
      tick();
      total++;
      if (halted !== 1'b1 || pc !== 32'h10 || id_valid !== 1'b0 || fetch_count !== 32'd4) begin
         bad++;
         $display("FAIL halt_enter got h=%b pc=%h v=%b cnt=%0d exp h=1 pc=10 v=0 cnt=4", halted, pc, id_valid, fetch_count);
      end
      resume = 1'b1;
      tick();
      total++; if (halted !== 1'b1 || pc !== 32'h10) begin bad++; $display("FAIL halt_priority got h=%b pc=%h exp h=1 pc=10", halted, pc); end
      halt = 1'b0;
      tick();
      resume = 1'b0;
      total++;
      if (halted !== 1'b0 || id_valid !== 1'b0 || pc !== 32'h10) begin
         bad++;
         $display("FAIL resume_edge got h=%b v=%b pc=%h exp h=0 v=0 pc=10", halted, id_valid, pc);
      end
      tick();
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== 32'h104 || fetch_count !== 32'd5 || pc !== 32'h14) begin
         bad++;
         $display("FAIL resume_capture got v=%b idpc=%h inst=%h cnt=%0d pc=%h exp v=1 idpc=10 inst=104 cnt=5 pc=14", id_valid, id_pc, id_inst, fetch_count, pc);
      end
   endtask

   task automatic test_fault();
      redirect_valid = 1'b1;
      redirect_target = 32'h42;
      tick();
      total++;
      if (fault !== 1'b1 || pc !== 32'h14 || id_valid !== 1'b0 || halted !== 1'b0) begin
         bad++;
         $display("FAIL fault_enter got f=%b pc=%h v=%b h=%b exp f=1 pc=14 v=0 h=0", fault, pc, id_valid, halted);
      end
      redirect_target = 32'h80;
      halt = 1'b1;
      resume = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (fault !== 1'b1 || pc !== 32'h14 || id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd5) begin
            bad++;
            $display("FAIL fault_sticky[%0d] got f=%b pc=%h v=%b h=%b cnt=%0d exp f=1 pc=14 v=0 h=0 cnt=5", i, fault, pc, id_valid, halted, fetch_count);
         end
      end
      rst = 1'b0;
      tick();
      redirect_valid = 1'b0;
      halt = 1'b0;
      resume = 1'b0;
      total++;
      if (fault !== 1'b0 || pc !== 32'h0 || fetch_count !== 32'd0 || id_inst !== 32'h13) begin
         bad++;
         $display("FAIL fault_reset got f=%b pc=%h cnt=%0d inst=%h exp f=0 pc=0 cnt=0 inst=13", fault, pc, fetch_count, id_inst);
      end
      rst = 1'b1;
      tick();
      total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin bad++; $display("FAIL fault_restart got v=%b idpc=%h exp v=1 idpc=0", id_valid, id_pc); end
   endtask

   task automatic test_wrap();
      w_rst = 1'b0;
      tick();
      total++; if (w_pc !== 32'hFFFF_FFFC || w_imem_addr !== 6'd63) begin bad++; $display("FAIL wrap_reset got pc=%h addr=%0d exp pc=fffffffc addr=63", w_pc, w_imem_addr); end
      w_rst = 1'b1;
      tick();
      total++;
      if (w_id_pc !== 32'hFFFF_FFFC || w_id_pc_plus4 !== 32'h0 || w_pc !== 32'h0 || w_id_inst !== 32'h13F || w_id_valid !== 1'b1) begin
         bad++;
         $display("FAIL wrap_first got idpc=%h p4=%h pc=%h inst=%h v=%b exp idpc=fffffffc p4=0 pc=0 inst=13f v=1", w_id_pc, w_id_pc_plus4, w_pc, w_id_inst, w_id_valid);
      end
      tick();
      total++;
      if (w_id_pc !== 32'h0 || w_id_inst !== 32'h100 || w_fetch_count !== 32'd2) begin
         bad++;
         $display("FAIL wrap_second got idpc=%h inst=%h cnt=%0d exp idpc=0 inst=100 cnt=2", w_id_pc, w_id_inst, w_fetch_count);
      end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall();
      test_redirect_stall();
      test_flush_stall();
      test_halt_resume();
      test_fault();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_stage_unit.md
# if_stage_unit

Parametrised instruction-fetch stage for the pipelined successor of the single-cycle RISC-V datapath. It owns the program counter, drives the word-addressed instruction memory, and captures the fetched word into an IF/ID pipeline register. Compared with the single-cycle PC path it adds:
- stall, flush and redirect control;
- a halt/resume state machine;
- misaligned-target fault detection;
- a fetch counter for the board debug display.

## Interface
Parameters:
- XLEN, 32, PC and datapath width.
- IMEM_AW, 6, instruction-memory word-index width.
- RESET_VECTOR, 0, PC value after reset (word aligned).
- NOP_INST, 32'h0000_0013, word placed in id_inst on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  squash IF/ID contents (bubble); PC advances normally.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_target  in  XLEN  new PC.
- halt  in  1  pc_halt from the control unit (ecall/ebreak/fence).
- resume  in  1  leave HALTED.
- imem_addr  out  IMEM_AW  = pc[IMEM_AW+1:2]; combinational memory read.
- imem_inst  in  32  instruction word for imem_addr, same cycle.
- pc  out  XLEN  current fetch PC.
- id_valid  out  1  IF/ID holds a real instruction.
- id_inst  out  32  registered instruction.
- id_pc  out  XLEN  PC of id_inst.
- id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^XLEN.
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT.
- fetch_count  out  32  number of valid words loaded into IF/ID; wraps at 2^32.

## Operation
States: RUN, HALTED, FAULT. RUN is entered after reset.

RUN transitions:
- redirect_valid with redirect_target[1:0] != 0 -> FAULT. PC is unchanged and IF/ID is bubbled.
- Otherwise, halt -> HALTED.
- HALTED -> RUN only on resume. halt has priority if both are high.
- FAULT: exit only by reset. stall, flush, redirect, halt and resume are all ignored.

PC update in RUN, priority order:
1. Aligned redirect_valid -> PC = redirect_target. This wins over stall, and over halt, which still takes effect in the same cycle.
2. halt or stall -> PC holds.
3. Otherwise PC = PC + 4, wrapping modulo 2^XLEN.

PC is held in HALTED and FAULT.

IF/ID update, priority order:
1. Any redirect_valid, flush, halt, or state != RUN -> bubble: id_valid = 0, id_inst = NOP_INST. id_pc and id_pc_plus4 hold.
2. stall -> all IF/ID fields hold.
3. Otherwise capture: id_valid = 1, id_inst = imem_inst, id_pc = pc, id_pc_plus4 = pc + 4.

Other rules:
- fetch_count increments only on a capture in which id_valid is set to 1.
- stall together with flush: flush wins; PC holds because of stall.
- Address bits above IMEM_AW+1 are ignored by memory indexing but retained in pc.

## Timing
- Reset values: pc = RESET_VECTOR, id_valid = 0, id_inst = NOP_INST, id_pc = 0, id_pc_plus4 = 0, halted = 0, fault = 0, fetch_count = 0, state = RUN.
- Reset asserted mid-operation overrides every other input on that edge.
- Fetch latency: imem_addr is combinational from pc. The word for pc appears in id_inst one edge later.
- Redirect penalty: redirect sampled at edge N -> pc = target after N. The word at the target is valid in IF/ID after N+1. The slot between is a bubble.
- Halt: after the sampling edge, halted = 1 and id_valid = 0. Resume at edge M -> the first new capture happens at M+1.
- No combinational path from any control input to any output other than imem_addr (which depends on pc only).

## Test plan
- Reset and sequential fetch: rst low for 2 cycles, memory word k = 32'h100+k. After rst goes high, id_pc steps 0, 4, 8, 12; id_inst = 0x100, 0x101, ...; fetch_count = 4 after 4 captures.
- Stall: assert stall for 3 cycles at pc = 8. pc, id_inst and id_pc hold for exactly 3 edges; fetch_count is frozen; sequential fetch resumes afterwards.
- Redirect plus stall: stall = 1 and redirect to 0x40 in the same cycle. pc = 0x40 next cycle, id_valid = 0; then id_pc = 0x40 with id_valid = 1.
- Misaligned redirect: target 0x42. fault = 1, pc is unchanged, id_valid = 0. fault stays 1 through later halt, resume and redirect inputs, and clears only after rst is held low for one edge.
- Halt/resume: halt at pc = 0x10. halted = 1, pc stays 0x10, id_valid = 0. resume -> next capture has id_pc = 0x10. halt and resume together keep the block halted.
- Wrap: RESET_VECTOR = 32'hFFFF_FFFC. First capture gives id_pc_plus4 = 0 and the next pc = 0.
